// File: rtl/timer_cc_if.sv
// timer_cc_if: register-file side of the timer core.
//   Configuration (driven by the register file): tc_en, tc_rst, dir, opm,
//   tarr, tpsc, ccr, ch_mode, irq_en, irq_clr, plus the raw cap_in pins.
//   Status (driven by the timer): tcnt, cc_out, cap_val, irq_flags,
//   cap_ovr, irq, running.
// Handshake: none. Every configuration signal is a level the timer samples on
// each rising clk edge; irq_clr bits are single-cycle write-1-to-clear pulses.
// There is no valid/ready pair because the register file never stalls.
interface timer_cc_if #(
  parameter int BITS_WIDTH = 32,
  parameter int CHANNELS   = 4
);
  logic                           tc_en;
  logic                           tc_rst;
  logic                           dir;
  logic                           opm;
  logic [BITS_WIDTH-1:0]          tarr;
  logic [BITS_WIDTH-1:0]          tpsc;
  logic [CHANNELS*BITS_WIDTH-1:0] ccr;
  logic [CHANNELS-1:0]            ch_mode;
  logic [CHANNELS-1:0]            cap_in;
  logic [CHANNELS:0]              irq_en;
  logic [CHANNELS:0]              irq_clr;
  logic [BITS_WIDTH-1:0]          tcnt;
  logic [CHANNELS-1:0]            cc_out;
  logic [CHANNELS*BITS_WIDTH-1:0] cap_val;
  logic [CHANNELS:0]              irq_flags;
  logic [CHANNELS-1:0]            cap_ovr;
  logic                           irq;
  logic                           running;

  modport master (
    output tc_en, tc_rst, dir, opm, tarr, tpsc, ccr, ch_mode, cap_in,
           irq_en, irq_clr,
    input  tcnt, cc_out, cap_val, irq_flags, cap_ovr, irq, running
  );

  modport slave (
    input  tc_en, tc_rst, dir, opm, tarr, tpsc, ccr, ch_mode, cap_in,
           irq_en, irq_clr,
    output tcnt, cc_out, cap_val, irq_flags, cap_ovr, irq, running
  );
endinterface

// File: rtl/timer_cc.sv
// timer_cc: prescaled up/down timer with auto-reload, one-pulse mode and
// CHANNELS compare/capture channels with sticky interrupt flags.
// Ports:
//   clk      - clock
//   n_rst    - asynchronous active-low reset
//   bus      - timer_cc_if.slave: configuration in, counter/capture/flags out
//   state_o  - current FSM state (IDLE=0, RUN=1, PAUSE=2, DONE=3)
module timer_cc #(
  parameter int BITS_WIDTH = 32,
  parameter int CHANNELS   = 4
) (
  input  logic       clk,
  input  logic       n_rst,
  timer_cc_if.slave  bus,
  output logic [1:0] state_o
);
  localparam int W = BITS_WIDTH;
  localparam int C = CHANNELS;
  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2, DONE = 2'd3} state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   tcnt_q, tcnt_d;
  logic [W-1:0]   psc_q, psc_d;
  logic           dir_q, dir_d;
  logic [C*W-1:0] shadow_q, shadow_d;
  logic [C*W-1:0] cap_q, cap_d;
  logic [C:0]     flags_q, flags_d;
  logic [C-1:0]   ovr_q, ovr_d;
  logic [C-1:0]   sync1_q, sync2_q, sync3_q;

  logic           tick;
  logic           upd;
  logic [C:0]     flag_set;
  logic [C-1:0]   ovr_set;
  logic [C-1:0]   cap_rise;

  assign cap_rise = sync2_q & ~sync3_q;

  always_comb begin
    state_d  = state_q;
    tcnt_d   = tcnt_q;
    psc_d    = psc_q;
    dir_d    = dir_q;
    shadow_d = shadow_q;
    cap_d    = cap_q;
    flag_set = '0;
    ovr_set  = '0;
    tick     = 1'b0;
    upd      = 1'b0;

    case (state_q)
      IDLE: begin
        // Start edge initialises the time base; no tick on this edge.
        if (bus.tc_en) begin
          state_d  = RUN;
          tcnt_d   = bus.dir ? bus.tarr : '0;
          psc_d    = '0;
          shadow_d = bus.ccr;
          dir_d    = bus.dir;
        end
      end
      RUN: begin
        // Leaving RUN swallows a tick that would have landed on this edge.
        if (!bus.tc_en) begin
          state_d = PAUSE;
        end else if (psc_q >= bus.tpsc) begin
          tick  = 1'b1;
          psc_d = '0;
        end else begin
          psc_d = psc_q + ONE;
        end
      end
      PAUSE: if (bus.tc_en) state_d = RUN;
      DONE:  if (!bus.tc_en) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (tick) begin
      if (!dir_q) begin
        if (tcnt_q >= bus.tarr) begin
          upd    = 1'b1;
          tcnt_d = '0;
        end else begin
          tcnt_d = tcnt_q + ONE;
        end
      end else begin
        if (tcnt_q == '0) begin
          upd    = 1'b1;
          tcnt_d = bus.tarr;
        end else begin
          tcnt_d = tcnt_q - ONE;
        end
      end
      for (int i = 0; i < C; i++) begin
        if (!bus.ch_mode[i] && (tcnt_d == shadow_q[i*W +: W])) flag_set[i+1] = 1'b1;
      end
    end

    // The wrap value already sits in tcnt_d, so one-pulse mode just parks there.
    if (upd) begin
      flag_set[0] = 1'b1;
      shadow_d    = bus.ccr;
      dir_d       = bus.dir;
      if (bus.opm) state_d = DONE;
    end

    if (state_q != IDLE) begin
      for (int i = 0; i < C; i++) begin
        if (bus.ch_mode[i] && cap_rise[i]) begin
          cap_d[i*W +: W] = tcnt_q;
          flag_set[i+1]   = 1'b1;
          if (flags_q[i+1]) ovr_set[i] = 1'b1;
        end
      end
    end

    // Set wins over a simultaneous clear.
    flags_d = (flags_q & ~bus.irq_clr) | flag_set;
    ovr_d   = (ovr_q & ~bus.irq_clr[C:1]) | ovr_set;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= IDLE;
      tcnt_q   <= '0;
      psc_q    <= '0;
      dir_q    <= 1'b0;
      shadow_q <= '0;
      cap_q    <= '0;
      flags_q  <= '0;
      ovr_q    <= '0;
      sync1_q  <= '0;
      sync2_q  <= '0;
      sync3_q  <= '0;
    end else if (bus.tc_rst) begin
      state_q  <= IDLE;
      tcnt_q   <= '0;
      psc_q    <= '0;
      dir_q    <= 1'b0;
      shadow_q <= '0;
      cap_q    <= '0;
      flags_q  <= '0;
      ovr_q    <= '0;
      sync1_q  <= '0;
      sync2_q  <= '0;
      sync3_q  <= '0;
    end else begin
      state_q  <= state_d;
      tcnt_q   <= tcnt_d;
      psc_q    <= psc_d;
      dir_q    <= dir_d;
      shadow_q <= shadow_d;
      cap_q    <= cap_d;
      flags_q  <= flags_d;
      ovr_q    <= ovr_d;
      sync1_q  <= bus.cap_in;
      sync2_q  <= sync1_q;
      sync3_q  <= sync2_q;
    end
  end

  always_comb begin
    bus.cc_out = '0;
    for (int i = 0; i < C; i++) begin
      bus.cc_out[i] = (state_q != IDLE) && !bus.ch_mode[i] && (tcnt_q < shadow_q[i*W +: W]);
    end
  end

  assign bus.tcnt      = tcnt_q;
  assign bus.cap_val   = cap_q;
  assign bus.irq_flags = flags_q;
  assign bus.cap_ovr   = ovr_q;
  assign bus.irq       = |(flags_q & bus.irq_en);
  assign bus.running   = (state_q == RUN);
  assign state_o       = state_q;
endmodule

// File: tb/tb_timer_cc.sv
module tb_timer_cc;
  localparam int BW = 8;
  localparam int CH = 2;

  logic       clk;
  logic       n_rst;
  logic [1:0] state_o;
  int         total;
  int         bad;
  logic [BW-1:0] exp_q[$];

  timer_cc_if #(.BITS_WIDTH(BW), .CHANNELS(CH)) bus ();

  timer_cc #(.BITS_WIDTH(BW), .CHANNELS(CH)) dut (
    .clk     (clk),
    .n_rst   (n_rst),
    .bus     (bus),
    .state_o (state_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_trst();
    bus.tc_en  = 1'b0;
    bus.tc_rst = 1'b1;
    step();
    bus.tc_rst = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // scoreboard
  task automatic sb_push(input logic [BW-1:0] v);
    exp_q.push_back(v);
  endtask

  task automatic sb_check(input string tag, input logic [BW-1:0] obs);
    logic [BW-1:0] e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $error("FAIL %s got=%0h exp=<empty queue>", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        bad++;
        $error("FAIL %s got=%0h exp=%0h", tag, obs, e);
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    n_rst = 1'b0;
    bus.tc_en = 1'b0; bus.tc_rst = 1'b0; bus.dir = 1'b0; bus.opm = 1'b0;
    bus.tarr = '0; bus.tpsc = '0; bus.ccr = '0; bus.ch_mode = '0;
    bus.cap_in = '0; bus.irq_en = '0; bus.irq_clr = '0;
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    step();

    // reset state
    chk("rst_tcnt",  bus.tcnt, 0);
    chk("rst_cc",    bus.cc_out, 0);
    chk("rst_cap",   bus.cap_val, 0);
    chk("rst_flags", bus.irq_flags, 0);
    chk("rst_ovr",   bus.cap_ovr, 0);
    chk("rst_irq",   bus.irq, 0);
    chk("rst_run",   bus.running, 0);
    chk("rst_state", state_o, 0);

    // up count, tpsc=1 tarr=3
    bus.tpsc = 8'd1; bus.tarr = 8'd3;
    for (int k = 0; k < 9; k++) sb_push(BW'((k / 2) % 4));
    bus.tc_en = 1'b1;
    for (int k = 0; k < 9; k++) begin
      step();
      sb_check("up_tcnt", bus.tcnt);
    end
    chk("up_flag0", bus.irq_flags[0], 1);
    chk("up_irq_masked", bus.irq, 0);
    bus.irq_en = 3'b001;
    #1;
    chk("up_irq_enabled", bus.irq, 1);
    bus.irq_en = '0;

    // down count, one-pulse
    do_trst();
    bus.dir = 1'b1; bus.opm = 1'b1; bus.tpsc = 8'd0; bus.tarr = 8'd2;
    sb_push(8'd2); sb_push(8'd1); sb_push(8'd0); sb_push(8'd2); sb_push(8'd2);
    bus.tc_en = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      sb_check("opm_tcnt", bus.tcnt);
    end
    chk("opm_running", bus.running, 0);
    chk("opm_state_done", state_o, 3);
    chk("opm_flag0", bus.irq_flags[0], 1);
    bus.tc_en = 1'b0;
    step();
    chk("opm_state_idle", state_o, 0);
    bus.tc_en = 1'b1;
    step();
    chk("opm_restart_tcnt", bus.tcnt, 2);
    chk("opm_restart_run", bus.running, 1);
    bus.dir = 1'b0; bus.opm = 1'b0;

    // PWM, ccr0=3 then 7 mid-period
    do_trst();
    bus.tpsc = 8'd0; bus.tarr = 8'd9; bus.ccr = {8'd0, 8'd3}; bus.ch_mode = 2'b10;
    bus.tc_en = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step();
      sb_push(BW'(k % 10));
      sb_check("pwm_tcnt", bus.tcnt);
      chk("pwm_cc", bus.cc_out, {1'b0, ((k % 10) < ((k < 10) ? 3 : 7))});
      if (k == 2) chk("pwm_flag1_before", bus.irq_flags[1], 0);
      if (k == 3) chk("pwm_flag1_set", bus.irq_flags[1], 1);
      if (k == 4) bus.ccr = {8'd0, 8'd7};
    end

    // capture on channel 1, tcnt stable for 4 clocks
    do_trst();
    bus.tpsc = 8'd3; bus.tarr = 8'd20; bus.ch_mode = 2'b10; bus.irq_en = 3'b100;
    bus.tc_en = 1'b1;
    step();
    repeat (20) step();
    chk("cap_tcnt_5", bus.tcnt, 5);
    bus.cap_in = 2'b10;
    step(); step();
    chk("cap_not_yet", bus.cap_val[15:8], 0);
    step();
    chk("cap_val_5", bus.cap_val[15:8], 5);
    chk("cap_flag2", bus.irq_flags[2], 1);
    chk("cap_irq", bus.irq, 1);
    chk("cap_no_ovr", bus.cap_ovr, 0);
    bus.cap_in = 2'b00;
    step(); step();
    bus.cap_in = 2'b10;
    step(); step(); step();
    chk("cap_val_6", bus.cap_val[15:8], 6);
    chk("cap_ovr1", bus.cap_ovr, 2'b10);
    bus.irq_clr = 3'b100;
    step();
    bus.irq_clr = '0;
    chk("cap_clr_flag", bus.irq_flags[2], 0);
    chk("cap_clr_ovr", bus.cap_ovr, 0);
    chk("cap_clr_irq", bus.irq, 0);
    bus.irq_en = '0; bus.cap_in = '0;

    // pause / resume, then tc_rst with tc_en held high
    do_trst();
    bus.tpsc = 8'd0; bus.tarr = 8'd15; bus.ch_mode = '0; bus.ccr = '0;
    bus.tc_en = 1'b1;
    step();
    repeat (6) step();
    chk("pause_tcnt6", bus.tcnt, 6);
    bus.tc_en = 1'b0;
    step();
    chk("pause_hold", bus.tcnt, 6);
    chk("pause_state", state_o, 2);
    chk("pause_running", bus.running, 0);
    step();
    chk("pause_hold2", bus.tcnt, 6);
    bus.tc_en = 1'b1;
    step();
    chk("resume_tcnt6", bus.tcnt, 6);
    chk("resume_running", bus.running, 1);
    step();
    chk("resume_tcnt7", bus.tcnt, 7);
    bus.tc_rst = 1'b1;
    step();
    bus.tc_rst = 1'b0;
    chk("trst_tcnt", bus.tcnt, 0);
    chk("trst_state", state_o, 0);
    chk("trst_running", bus.running, 0);
    chk("trst_cc", bus.cc_out, 0);
    chk("trst_flags", bus.irq_flags, 0);
    step();
    chk("trst_restart_tcnt", bus.tcnt, 0);
    chk("trst_restart_run", bus.running, 1);
    step();
    chk("trst_restart_tcnt1", bus.tcnt, 1);

    // set beats clear on update flag, tarr=0 updates every tick
    do_trst();
    bus.tpsc = 8'd0; bus.tarr = 8'd0;
    bus.tc_en = 1'b1;
    step();
    chk("prio_start_flag", bus.irq_flags[0], 0);
    step();
    chk("prio_upd_flag", bus.irq_flags[0], 1);
    bus.irq_clr = 3'b001;
    step();
    chk("prio_set_wins", bus.irq_flags[0], 1);
    bus.irq_clr = '0; bus.tc_en = 1'b0;
    step();
    bus.irq_clr = 3'b001;
    step();
    bus.irq_clr = '0;
    chk("prio_clear", bus.irq_flags[0], 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/timer_cc.md
# timer_cc

Parametrised general-purpose timer: prescaler, up/down time base with auto-reload, one-pulse mode, and CHANNELS compare/capture channels with per-source interrupt flags. It is the next-generation peripheral timer core in the same register-driven environment. The bus register file drives its configuration inputs and consumes its counter, capture and flag outputs.

## Interface
- BITS_WIDTH, 32, width of counter, prescaler, reload, compare and capture values
- CHANNELS, 4, number of compare/capture channels (1..16)
- clk  in  1  clock
- n_rst  in  1  asynchronous, active-low reset
- tc_en  in  1  count enable (level)
- tc_rst  in  1  synchronous reset of the timer; has priority over everything except n_rst
- dir  in  1  0 = up count, 1 = down count; sampled only at start and at update events
- opm  in  1  one-pulse mode
- tarr  in  BITS_WIDTH  auto-reload value
- tpsc  in  BITS_WIDTH  prescaler divide value; one tick per tpsc+1 clocks
- ccr  in  CHANNELS*BITS_WIDTH  compare values; channel i occupies bits [i*BITS_WIDTH +: BITS_WIDTH]
- ch_mode  in  CHANNELS  per channel: 0 = compare, 1 = capture
- cap_in  in  CHANNELS  asynchronous capture inputs
- irq_en  in  CHANNELS+1  interrupt enables; bit 0 = update, bit i+1 = channel i
- irq_clr  in  CHANNELS+1  write-1-to-clear pulses for irq_flags
- tcnt  out  BITS_WIDTH  current count
- cc_out  out  CHANNELS  compare/PWM outputs
- cap_val  out  CHANNELS*BITS_WIDTH  captured counts
- irq_flags  out  CHANNELS+1  sticky event flags
- cap_ovr  out  CHANNELS  capture overrun flags; cleared together with the matching irq_flags bit
- irq  out  1  OR over (irq_flags & irq_en)
- running  out  1  high in state RUN

## Operation
- States:
  - IDLE: entered on reset and tc_rst; not yet initialised.
  - RUN: counting.
  - PAUSE: tc_en low after RUN; tcnt and psc_cnt hold.
  - DONE: one-pulse mode finished.
- Transitions:
  - IDLE→RUN on tc_en=1. On that edge: tcnt ← 0 (up) or tarr (down); psc_cnt ← 0; ccr shadows ← ccr; dir latched. No tick occurs on the start edge.
  - RUN→PAUSE on tc_en=0. PAUSE→RUN on tc_en=1, with no reload: counting resumes from the held values.
  - RUN→DONE on an update event while opm=1. DONE→IDLE on tc_en=0.
  - tc_rst from any state → IDLE.
- Prescaler, in RUN: if psc_cnt ≥ tpsc then tick and psc_cnt ← 0, else psc_cnt+1.
- Counter, on tick:
  - Up: tcnt ≥ tarr → tcnt ← 0 with an update event; otherwise tcnt+1.
  - Down: tcnt == 0 → tcnt ← tarr with an update event; otherwise tcnt−1.
- Update event actions:
  - Set irq_flags[0].
  - Reload the ccr shadows.
  - Re-latch dir.
  - In one-pulse mode, tcnt holds at the wrap value (0 for up, tarr for down) and the state goes to DONE.
- Compare (ch_mode=0):
  - cc_out[i] = (state≠IDLE) && tcnt < shadow[i]. This is combinational from registered tcnt and the shadow.
  - irq_flags[i+1] sets on the tick edge where the new tcnt equals shadow[i].
- Capture (ch_mode=1):
  - cap_in passes through a 2-FF synchroniser, then a third register for rising-edge detection.
  - Capture happens in any state except IDLE.
  - On a detected edge: cap_val[i] ← tcnt and irq_flags[i+1] sets. If the flag was already set, cap_ovr[i] also sets.
  - cc_out[i] = 0 in capture mode.
- Flags: set has priority over a simultaneous irq_clr on the same bit. Clearing bit i+1 also clears cap_ovr[i].
- tc_rst effects:
  - Clears tcnt, psc_cnt, irq_flags, cap_ovr, cap_val and the shadows.
  - Clears the synchroniser state.
  - Forces state IDLE.
- Width rules: all arithmetic is unsigned, BITS_WIDTH wide. Increment and decrement cannot wrap because the compares gate them. tarr=0 gives an update event on every tick.

## Timing
- Reset values (n_rst or tc_rst): tcnt=0, cc_out=0, cap_val=0, irq_flags=0, cap_ovr=0, irq=0, running=0, state IDLE.
- The first tick occurs tpsc+1 clocks after the start edge. tcnt then changes once every tpsc+1 clocks.
- irq asserts in the same cycle the flag is visible, one clock after the event edge.
- Capture latency: cap_in first sampled high at edge k. cap_val is loaded at edge k+2 with the tcnt value present before edge k+2. Pulses on cap_in must be high ≥2 clocks to be captured.
- Changes to ccr take effect at the next start or update event only. Changes to tarr and tpsc take effect immediately at the next compare.
- tc_en falling and a tick in the same cycle: the tick is not applied, because the state leaves RUN at that edge.

## Test plan
- Up count: tpsc=1, tarr=3, tc_en=1 → tcnt = 0,0,1,1,2,2,3,3,0 (changes every 2 clocks). irq_flags[0] sets on the wrap; irq=1 only if irq_en[0]=1.
- Down count with one-pulse: dir=1, opm=1, tpsc=0, tarr=2 → tcnt = 2,1,0,2, then holds 2 in DONE with running=0. Dropping tc_en returns to IDLE; re-enabling restarts at 2.
- PWM: tpsc=0, tarr=9, ccr0=3, compare mode → cc_out[0] high for 3 of every 10 counts. Writing ccr0=7 mid-period takes effect only after the next wrap. irq_flags[1] sets when tcnt becomes 3.
- Capture: ch_mode[1]=1, cap_in[1] rises at edge k while tcnt=5 is stable → cap_val[1]=5 at edge k+2 and irq_flags[2]=1. A second edge before clear → cap_ovr[1]=1. irq_clr[2] clears both.
- Pause/resume: disable at tcnt=6, re-enable → counting resumes at 6, then 7. tc_rst during RUN at tcnt=6 → all outputs 0 and state IDLE next cycle; re-enable starts at 0.
- Priority: irq_clr[0] asserted on the same edge as an update event → irq_flags[0] stays 1. tc_rst together with tc_en=1 → IDLE, tcnt=0.
